// File: rtl/piso_shiftreg.sv
// piso_shiftreg: LSB-first parallel-to-serial shifter; din/load/ready capture a word, en advances sout, busy/done frame it
module piso_shiftreg #(
  parameter int   N        = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  input  logic         load,
  output logic         ready,
  input  logic         en,
  output logic         sout,
  output logic         busy,
  output logic         done
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t        state;
  logic [N-1:0]  sh;
  logic [CW-1:0] cnt;
  assign ready = state == IDLE;
  assign busy  = state == SHIFT;
  assign sout  = busy ? sh[0] : IDLE_BIT;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (load) begin
          sh    <= din;
          cnt   <= CW'(N);
          state <= SHIFT;
        end
      end else if (en) begin
        sh  <= {IDLE_BIT, sh[N-1:1]};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/piso_shiftreg.md
# piso_shiftreg

Parallel-in, serial-out shift register with a load handshake and a per-bit shift enable. It is the transmit-side counterpart of the team's serial-in shift register. The first bit sent ends up at the receiver's LSB, so words are sent LSB first. A captured N-bit word is presented bit-by-bit on `sout`, advancing only on cycles where `en` is high. `busy` and a one-cycle `done` pulse allow chaining words back to back.

## Interface
- `N`, default 4: word width in bits; legal range 2..32.
- `IDLE_BIT`, default 1'b0: level driven on `sout` when no word is in flight; also the fill bit shifted in at the MSB.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset; one clock; synchronous, active-low.
- `din`  input  N  parallel word to transmit; sampled only on an accepted load.
- `load`  input  1  load request; accepted when `load && ready` at a rising edge.
- `ready`  output  1  high when a load can be accepted.
- `en`  input  1  shift enable; the current bit advances only on edges with `en`=1.
- `sout`  output  1  serial data; holds the current bit while `busy`, otherwise `IDLE_BIT`.
- `busy`  output  1  high while a word is in flight; intended to qualify the receiver's enable.
- `done`  output  1  one-cycle pulse after the last bit has been shifted out.

## Operation
- Internal state:
  - `sh[N-1:0]` is the shift register.
  - `cnt` counts the bits remaining; width is `$clog2(N+1)`; range 0..N.
  - A two-state FSM has states IDLE and SHIFT.
- Output decode:
  - `ready` = (state==IDLE).
  - `busy` = (state==SHIFT).
  - `sout` = `busy` ? `sh[0]` : `IDLE_BIT`.
  - `done` is registered.
- IDLE:
  - On `load`=1, set `sh`←`din` and `cnt`←N, then go to SHIFT.
  - `en` is ignored in IDLE.
- SHIFT:
  - On `en`=1, set `sh`←{`IDLE_BIT`, `sh[N-1:1]`} and `cnt`←`cnt`-1.
  - If `cnt`==1 on that edge, go to IDLE and set `done`←1.
  - On `en`=0, hold `sh` and `cnt`; `sout` is stable.
- `load` is ignored in SHIFT. A load asserted on the final-shift edge is dropped, because `ready`=0 on that edge. The word is not queued.
- `done` is 1 only for the single cycle following the final-shift edge; it is 0 otherwise.
- Bit order: bit k of the word (k=0..N-1) is on `sout` after k enabled shifts. A receiver doing {in, q[N-1:1]} on the same `en`/`busy` edges reconstructs `din` exactly.

## Timing
- Reset (`rst_n`=0 at an edge) forces these values at the next cycle, whatever the state (mid-word included):
  - state=IDLE, `sh`=0, `cnt`=0.
  - `ready`=1, `busy`=0, `done`=0, `sout`=`IDLE_BIT`.
  - A word in flight is discarded; there is no partial `done`.
- `load`/`en` sampled with `rst_n`=0 have no effect.
- Load latency: after an accepting edge E0, bit 0 appears on `sout` in the cycle following E0, and `busy` rises in the same cycle.
- With `en` held at 1:
  - Bits 0..N-1 occupy cycles 1..N after E0.
  - Edge EN consumes bit N-1.
  - `done`=1, `ready`=1 and `busy`=0 in cycle N+1.
- Stalls: each cycle with `en`=0 in SHIFT extends the word by one cycle. The total duration is N enabled edges, regardless of gaps.
- Back-to-back: a `load` in the `done` cycle is accepted. The next word's bit 0 follows in the next cycle, with exactly one IDLE cycle between words.
- The receiver samples `sout` on the same edge at which this block shifts (`en` && `busy`).

## Test plan
- Reset: drive `rst_n`=0 for 2 cycles with `load`=1 and `en`=1 → `ready`=1, `busy`=0, `done`=0, `sout`=0; nothing loads.
- Basic word: N=4, load `din`=4'b1010 with `en`=1 continuously → `sout`=0,1,0,1 in cycles 1..4; `done`=1 in cycle 5 only; `busy` is high in cycles 1..4.
- Stalls: `din`=4'b0011, `en` pattern 1,0,0,1,1,0,1 → `sout` holds each bit through its stall cycles; sequence 1,1,0,0; `done` fires after the 4th enabled edge (cycle 8).
- Load while busy: load 4'b1111, then assert `load` with `din`=4'b0000 in cycles 2 and 4 (including the final-shift edge) → those loads are ignored; output is 1,1,1,1 then `IDLE_BIT`; `done` fires once.
- Back-to-back and reset mid-word:
  - Load 4'b0110, then load 4'b1001 in the `done` cycle → 0,1,1,0,(idle),1,0,0,1.
  - Then load 4'b1100 and pull `rst_n` low after 2 bits → next cycle IDLE, `sout`=`IDLE_BIT`, no `done`.
- Loopback: connect to the serial-in register (its `en` = `busy`, its `in` = `sout`) and send 4'b0110 → the receiver holds q=4'b0110 in the `done` cycle.
